// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encodings.
package serial_sub_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_SHIFT = 2'd1;
  localparam logic [1:0] ENC_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    SHIFT = ENC_SHIFT,
    DONE  = ENC_DONE
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: x - y - bin -> difference d, borrow-out bout.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) behind a start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | one bit per cycle through the cell
  // DONE  | publish result on the edge leaving this state; start accepted here too
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic cell_d, cell_b;
  logic accept;

  full_subtractor u_cell (
    .x   (sa_q[0]),
    .y   (sb_q[0]),
    .bin (borrow_q),
    .d   (cell_d),
    .bout(cell_b)
  );

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: state_d = IDLE;
      SHIFT: begin
        sr_d     = {cell_d, sr_q[WIDTH-1:1]};
        sa_d     = {1'b0, sa_q[WIDTH-1:1]};
        sb_d     = {1'b0, sb_q[WIDTH-1:1]};
        borrow_d = cell_b;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        diff_d  = sr_q;
        bout_d  = borrow_q;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = (a_msb_q != b_msb_q) && (sr_q[WIDTH-1] != a_msb_q);
`endif
      end
      default: state_d = IDLE;
    endcase
    // A start in DONE overrides the return to IDLE so back-to-back ops have no gap.
    if (accept) begin
      sa_d     = a;
      sb_d     = b;
      sr_d     = '0;
      borrow_d = 1'b0;
      cnt_d    = '0;
      state_d  = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d  = a[WIDTH-1];
      b_msb_d  = b[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor and its full_subtractor cell.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, bout;
  logic [WIDTH-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  logic fx, fy, fbin, fd, fbo;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  full_subtractor u_fs (
    .x   (fx),
    .y   (fy),
    .bin (fbin),
    .d   (fd),
    .bout(fbo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int r;
    r = int'(x) - int'(y) + (1 << WIDTH);
    return WIDTH'(r % (1 << WIDTH));
  endfunction

  function automatic logic ref_bout(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int sx, sy, r;
    sx = int'(x) - (x[WIDTH-1] ? (1 << WIDTH) : 0);
    sy = int'(y) - (y[WIDTH-1] ? (1 << WIDTH) : 0);
    r  = sx - sy;
    return (r < -(1 << (WIDTH - 1))) || (r > (1 << (WIDTH - 1)) - 1);
  endfunction

  task automatic check_result(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    check({tag, "_diff"}, 32'(diff), 32'(ref_diff(x, y)));
    check({tag, "_bout"}, 32'(bout), 32'(ref_bout(x, y)));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(x, y)));
`endif
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int lat;
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~x;
    b     = ~y;
    lat   = -1;
    for (int n = 1; n <= WIDTH + 6; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
    check_result(tag, x, y);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'(0));
    check({tag, "_hold"}, 32'(diff), 32'(ref_diff(x, y)));
  endtask

  initial begin
    logic [WIDTH-1:0] rx, ry;
    logic             saw_done, saw_busy;
    int               r;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    fx    = 1'b0;
    fy    = 1'b0;
    fbin  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_diff", 32'(diff), 32'(0));
    check("rst_bout", 32'(bout), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      fx   = v[2];
      fy   = v[1];
      fbin = v[0];
      #1;
      r = int'(fx) - int'(fy) - int'(fbin);
      check($sformatf("fs_d_%0d", v), 32'(fd), 32'(r & 1));
      check($sformatf("fs_bout_%0d", v), 32'(fbo), 32'(r < 0));
    end

    run_op("5m3", 8'h05, 8'h03);
    run_op("3m5", 8'h03, 8'h05);
    run_op("80m01", 8'h80, 8'h01);
    run_op("00m00", 8'h00, 8'h00);
    run_op("FFmFF", 8'hFF, 8'hFF);

    // Mid-SHIFT start ignored, then start during DONE chains a second op.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h05;
    b     = 8'h03;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 8'h09;
    b     = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    check("mid_busy", 32'(busy), 32'(1));
    repeat (WIDTH - 4) @(posedge clk);
    #1;
    check("done_state_busy", 32'(busy), 32'(0));
    check("done_state_done", 32'(done), 32'(0));
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h20;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'hAA;
    b     = 8'h55;
    check("chain1_done", 32'(done), 32'(1));
    check_result("chain1", 8'h05, 8'h03);
    check("chain2_no_gap", 32'(busy), 32'(1));
    repeat (WIDTH + 1) @(posedge clk);
    #1;
    check("chain2_done", 32'(done), 32'(1));
    check_result("chain2", 8'h10, 8'h20);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h07;
    b     = 8'h02;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_diff", 32'(diff), 32'(0));
    check("arst_bout", 32'(bout), 32'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    repeat (WIDTH + 4) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | done;
      saw_busy = saw_busy | busy;
    end
    check("arst_no_done", 32'(saw_done), 32'(0));
    check("arst_no_busy", 32'(saw_busy), 32'(0));
    run_op("after_rst", 8'h07, 8'h02);

    for (int i = 0; i < 20; i++) begin
      rx = WIDTH'($urandom);
      ry = WIDTH'($urandom);
      run_op($sformatf("rnd%0d", i), rx, ry);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
